// File: rtl/deep_chain_result_fifo.sv
// FWFT result FIFO for the deep assign chain, with rotate-XOR signature, push counter and sticky handshake-error flag.
// Define DCRF_MINMAX_EN to add running min/max outputs.
module deep_chain_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dcrf_in_valid,
    input  logic [15:0]              dcrf_in_data,
    output logic                     dcrf_in_ready,
    output logic                     dcrf_out_valid,
    output logic [15:0]              dcrf_out_data,
    input  logic                     dcrf_out_ready,
    input  logic                     dcrf_sig_clr,
    output logic [$clog2(DEPTH):0]   dcrf_level,
    output logic [15:0]              dcrf_sig,
    output logic [CNT_W-1:0]         dcrf_total,
    output logic                     dcrf_proto_err
`ifdef DCRF_MINMAX_EN
    ,
    output logic [15:0]              dcrf_min,
    output logic [15:0]              dcrf_max
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_e;

    occ_e              state_q, state_d;
    logic [15:0]       mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic [15:0]       sig_q, sig_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              perr_q, perr_d;
    logic              prev_stall_q;
    logic [15:0]       prev_data_q;
    logic              push, pop, violation;

    assign push      = dcrf_in_valid && dcrf_in_ready;
    assign pop       = dcrf_out_valid && dcrf_out_ready;
    // A stalled word must stay valid and unchanged until it is accepted.
    assign violation = prev_stall_q && (!dcrf_in_valid || (dcrf_in_data != prev_data_q));

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push) state_d = PARTIAL;
            PARTIAL: begin
                if (level_d == LW'(DEPTH)) begin
                    state_d = FULL;
                end else if (level_d == '0) begin
                    state_d = EMPTY;
                end
            end
            FULL:    if (pop) state_d = PARTIAL;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        dcrf_in_ready  = (state_q != FULL);
        dcrf_out_valid = (state_q != EMPTY);
        dcrf_out_data  = dcrf_out_valid ? mem_q[rd_ptr_q] : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dcrf_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    // Clear wins over the update rules; a push in the clear cycle seeds the new run.
    always_comb begin
        sig_d   = sig_q;
        total_d = total_q;
        perr_d  = perr_q || violation;
        if (dcrf_sig_clr) begin
            sig_d   = push ? dcrf_in_data : 16'h0000;
            total_d = push ? CNT_W'(1) : '0;
            perr_d  = 1'b0;
        end else if (push) begin
            sig_d   = {sig_q[14:0], sig_q[15]} ^ dcrf_in_data;
            total_d = total_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q        <= '0;
            total_q      <= '0;
            perr_q       <= 1'b0;
            prev_stall_q <= 1'b0;
            prev_data_q  <= '0;
        end else begin
            sig_q        <= sig_d;
            total_q      <= total_d;
            perr_q       <= perr_d;
            prev_stall_q <= dcrf_in_valid && !dcrf_in_ready;
            prev_data_q  <= dcrf_in_data;
        end
    end

    assign dcrf_level     = level_q;
    assign dcrf_sig       = sig_q;
    assign dcrf_total     = total_q;
    assign dcrf_proto_err = perr_q;

`ifdef DCRF_MINMAX_EN
    logic [15:0] min_q, max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= 16'hFFFF;
            max_q <= 16'h0000;
        end else if (dcrf_sig_clr) begin
            min_q <= push ? dcrf_in_data : 16'hFFFF;
            max_q <= push ? dcrf_in_data : 16'h0000;
        end else if (push) begin
            if (dcrf_in_data < min_q) min_q <= dcrf_in_data;
            if (dcrf_in_data > max_q) max_q <= dcrf_in_data;
        end
    end

    assign dcrf_min = min_q;
    assign dcrf_max = max_q;
`endif

endmodule

// File: tb/tb_deep_chain_result_fifo.sv
// Self-checking bench for deep_chain_result_fifo: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed expectations. Define DCRF_MINMAX_EN to also cover min/max.
module tb_deep_chain_result_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              inValid = 1'b0;
    logic [15:0]       inData = 16'h0000;
    logic              inReady;
    logic              outValid;
    logic [15:0]       outData;
    logic              outReady = 1'b0;
    logic              sigClr = 1'b0;
    logic [LW-1:0]     level;
    logic [15:0]       sig;
    logic [CNT_W-1:0]  total;
    logic              protoErr;
`ifdef DCRF_MINMAX_EN
    logic [15:0]       dMin, dMax;
`endif

    int vectors = 0;
    int miscompares = 0;

    deep_chain_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dcrf_in_valid  (inValid),
        .dcrf_in_data   (inData),
        .dcrf_in_ready  (inReady),
        .dcrf_out_valid (outValid),
        .dcrf_out_data  (outData),
        .dcrf_out_ready (outReady),
        .dcrf_sig_clr   (sigClr),
        .dcrf_level     (level),
        .dcrf_sig       (sig),
        .dcrf_total     (total),
        .dcrf_proto_err (protoErr)
`ifdef DCRF_MINMAX_EN
        ,
        .dcrf_min       (dMin),
        .dcrf_max       (dMax)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a plain queue, counters are plain integers.
    logic [15:0]       mq [$];
    logic [15:0]       mSig = 16'h0000;
    logic [CNT_W-1:0]  mTotal = '0;
    bit                mErr = 1'b0;
    bit                mPrevStall = 1'b0;
    logic [15:0]       mPrevData = 16'h0000;
    logic [15:0]       mMin = 16'hFFFF;
    logic [15:0]       mMax = 16'h0000;

    always @(posedge clk or negedge rst_n) begin : modelStep
        bit rdy, vld, doPush, doPop, viol;
        if (!rst_n) begin
            mq.delete();
            mSig = 16'h0000;
            mTotal = '0;
            mErr = 1'b0;
            mPrevStall = 1'b0;
            mPrevData = 16'h0000;
            mMin = 16'hFFFF;
            mMax = 16'h0000;
        end else begin
            rdy    = (mq.size() != DEPTH);
            vld    = (mq.size() != 0);
            doPush = inValid && rdy;
            doPop  = vld && outReady;
            viol   = mPrevStall && (!inValid || inData != mPrevData);
            if (sigClr) begin
                mSig   = doPush ? inData : 16'h0000;
                mTotal = doPush ? CNT_W'(1) : '0;
                mErr   = 1'b0;
                mMin   = doPush ? inData : 16'hFFFF;
                mMax   = doPush ? inData : 16'h0000;
            end else begin
                if (viol) mErr = 1'b1;
                if (doPush) begin
                    mSig   = ((mSig << 1) | (mSig >> 15)) ^ inData;
                    mTotal = mTotal + 1'b1;
                    if (inData < mMin) mMin = inData;
                    if (inData > mMax) mMax = inData;
                end
            end
            if (doPop) void'(mq.pop_front());
            if (doPush) mq.push_back(inData);
            mPrevStall = inValid && !rdy;
            mPrevData  = inData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        checkOutput("m_in_ready",  32'(inReady),  32'(mq.size() != DEPTH));
        checkOutput("m_out_valid", 32'(outValid), 32'(mq.size() != 0));
        checkOutput("m_out_data",  32'(outData),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        checkOutput("m_level",     32'(level),    32'(mq.size()));
        checkOutput("m_sig",       32'(sig),      32'(mSig));
        checkOutput("m_total",     32'(total),    32'(mTotal));
        checkOutput("m_proto_err", 32'(protoErr), 32'(mErr));
`ifdef DCRF_MINMAX_EN
        checkOutput("m_min",       32'(dMin),     32'(mMin));
        checkOutput("m_max",       32'(dMax),     32'(mMax));
`endif
    end

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic ordy, input logic clr);
        inValid  = v;
        inData   = d;
        outReady = ordy;
        sigClr   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level", 32'(level), 32'h0);
        checkOutput("rst_in_ready", 32'(inReady), 32'h1);
        checkOutput("rst_out_valid", 32'(outValid), 32'h0);
        checkOutput("rst_sig", 32'(sig), 32'h0);
        rst_n = 1'b1;

        // Basic push/pop with signature
        applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
        checkOutput("t1_sig1", 32'(sig), 32'h0001);
        checkOutput("t1_out1", 32'(outData), 32'h0001);
        applyStimulus(1'b1, 16'h0002, 1'b1, 1'b0);
        checkOutput("t1_sig2", 32'(sig), 32'h0000);
        checkOutput("t1_total", 32'(total), 32'h2);
        checkOutput("t1_out2", 32'(outData), 32'h0002);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t1_empty", 32'(level), 32'h0);

        // Fill to full, hold the fifth word, then drain
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0014, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0014, 1'b0, 1'b0);
        checkOutput("t2_level_full", 32'(level), 32'h4);
        checkOutput("t2_in_ready", 32'(inReady), 32'h0);
        checkOutput("t2_perr", 32'(protoErr), 32'h0);
        checkOutput("t2_head", 32'(outData), 32'h0010);
        applyStimulus(1'b1, 16'h0014, 1'b1, 1'b0);
        checkOutput("t2_lvl3a", 32'(level), 32'h3);
        checkOutput("t2_head11", 32'(outData), 32'h0011);
        applyStimulus(1'b1, 16'h0014, 1'b1, 1'b0);
        checkOutput("t2_lvl3b", 32'(level), 32'h3);
        checkOutput("t2_head12", 32'(outData), 32'h0012);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t2_head13", 32'(outData), 32'h0013);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t2_head14", 32'(outData), 32'h0014);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t2_drained", 32'(level), 32'h0);
        checkOutput("t2_out0", 32'(outData), 32'h0);
        checkOutput("t2_total", 32'(total), 32'h7);

        // Rotate wrap from a cleared signature
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        checkOutput("t3_clr_sig", 32'(sig), 32'h0);
        checkOutput("t3_clr_total", 32'(total), 32'h0);
        applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0);
        checkOutput("t3_sig8000", 32'(sig), 32'h8000);
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
        checkOutput("t3_sigwrap", 32'(sig), 32'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Changing data while stalled sets the sticky error
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        checkOutput("t4_perr_before", 32'(protoErr), 32'h0);
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
        checkOutput("t4_perr_set", 32'(protoErr), 32'h1);
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
        checkOutput("t4_perr_sticky", 32'(protoErr), 32'h1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("t4_clr_perr", 32'(protoErr), 32'h0);
        checkOutput("t4_clr_sig", 32'(sig), 32'h0);
        checkOutput("t4_clr_total", 32'(total), 32'h0);
        checkOutput("t4_clr_level", 32'(level), 32'h4);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t4_perr_after", 32'(protoErr), 32'h0);

        // Steady state at level 2 with simultaneous push and pop
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t5_level2", 32'(level), 32'h2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
            checkOutput("t5_level_hold", 32'(level), 32'h2);
        end
        checkOutput("t5_head", 32'(outData), 32'h0106);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t5_drained", 32'(level), 32'h0);

        // Clear with push, burst, then reset mid-burst
        applyStimulus(1'b1, 16'h0300, 1'b0, 1'b1);
        checkOutput("t6_clr_push_sig", 32'(sig), 32'h0300);
        checkOutput("t6_clr_push_total", 32'(total), 32'h1);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hF000, 1'b0, 1'b0);
        checkOutput("t6_sig", 32'(sig), 32'hFC20);
        checkOutput("t6_level", 32'(level), 32'h3);
`ifdef DCRF_MINMAX_EN
        checkOutput("t6_min", 32'(dMin), 32'h0010);
        checkOutput("t6_max", 32'(dMax), 32'hF000);
`endif
        inData = 16'h1234;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_level", 32'(level), 32'h0);
        checkOutput("t6_rst_sig", 32'(sig), 32'h0);
        checkOutput("t6_rst_in_ready", 32'(inReady), 32'h1);
        checkOutput("t6_rst_out_data", 32'(outData), 32'h0);
`ifdef DCRF_MINMAX_EN
        checkOutput("t6_rst_min", 32'(dMin), 32'hFFFF);
        checkOutput("t6_rst_max", 32'(dMax), 32'h0000);
`endif
        inValid = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0);
        checkOutput("t6_post_rst_head", 32'(outData), 32'h0042);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
